// File: rtl/adc_responder.sv
// ADC-side responder: synchronizes the controller's serial interface,
// captures a sample on conversion start, models the conversion time,
// then shifts the 12-bit result out MSB first while collecting a 6-bit
// configuration word from adc_sdi.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an adc_convst rise; adc_sdo held low
// CONVERT | conversion timer running; busy high; serial clock ignored
// SHIFT   | result shifted out on adc_clk falls, config bits in on rises
module adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        adc_clk,
    input  logic        adc_convst,
    input  logic        adc_sdi,
    output logic        adc_sdo,
    input  logic [11:0] sample_data,
    output logic [2:0]  ch_sel,
    output logic [5:0]  cfg_word,
    output logic        cfg_valid,
    output logic        conv_strobe,
    output logic        busy
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] scs_q, scs_d;
    logic [SYNC_STAGES-1:0] ssdi_q, ssdi_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   cs_armed_q, cs_armed_d;

    logic clk_sync, cs_sync, sdi_sync;
    logic clk_rise, clk_fall, cs_rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      conv_q, conv_d;
    logic [3:0]       idx_q, idx_d;
    logic [2:0]       cfg_cnt_q, cfg_cnt_d;
    logic [5:0]       cfg_sr_q, cfg_sr_d;
    logic             cfg_pend_q, cfg_pend_d;
    logic [5:0]       cfg_word_q, cfg_word_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             strobe_q, strobe_d;
    logic             sdo_q, sdo_d;

    assign clk_sync = sclk_q[SYNC_STAGES-1];
    assign cs_sync  = scs_q[SYNC_STAGES-1];
    assign sdi_sync = ssdi_q[SYNC_STAGES-1];

    // vld_q marks when the chains hold real pin samples; cs_armed_q then
    // requires a synchronized low on adc_convst before any rise counts, so
    // a level held high across reset never starts a conversion.
    assign clk_rise = clk_sync & ~clk_prev_q;
    assign clk_fall = ~clk_sync & clk_prev_q;
    assign cs_rise  = cs_sync & ~cs_prev_q & cs_armed_q;

    // Next values of the synchronizer chains and edge-detect registers
    always_comb begin
        sclk_d     = {sclk_q[SYNC_STAGES-2:0], adc_clk};
        scs_d      = {scs_q[SYNC_STAGES-2:0], adc_convst};
        ssdi_d     = {ssdi_q[SYNC_STAGES-2:0], adc_sdi};
        vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
        clk_prev_d = clk_sync;
        cs_prev_d  = cs_sync;
        cs_armed_d = cs_armed_q | (vld_q[SYNC_STAGES-1] & ~cs_sync);
    end

    // Synchronizer and edge-detect registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_q     <= '0;
            scs_q      <= '0;
            ssdi_q     <= '0;
            vld_q      <= '0;
            clk_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
            cs_armed_q <= 1'b0;
        end else begin
            sclk_q     <= sclk_d;
            scs_q      <= scs_d;
            ssdi_q     <= ssdi_d;
            vld_q      <= vld_d;
            clk_prev_q <= clk_prev_d;
            cs_prev_q  <= cs_prev_d;
            cs_armed_q <= cs_armed_d;
        end
    end

    // Next-state and datapath logic; a convst rise outranks serial clock
    // edges, and rise/fall are handled exclusively
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        conv_d      = conv_q;
        idx_d       = idx_q;
        cfg_cnt_d   = cfg_cnt_q;
        cfg_sr_d    = cfg_sr_q;
        cfg_pend_d  = 1'b0;
        cfg_valid_d = cfg_pend_q;
        cfg_word_d  = cfg_pend_q ? cfg_sr_q : cfg_word_q;
        strobe_d    = 1'b0;
        sdo_d       = sdo_q;

        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (cs_rise) begin
                    state_d  = CONVERT;
                    conv_d   = sample_data;
                    strobe_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                end
            end
            CONVERT: begin
                if (cnt_q == '0) begin
                    state_d   = SHIFT;
                    sdo_d     = conv_q[11];
                    idx_d     = 4'd11;
                    cfg_cnt_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d  = CONVERT;
                    conv_d   = sample_data;
                    strobe_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                    sdo_d    = 1'b0;
                end else if (clk_rise) begin
                    if (cfg_cnt_q < 3'd6) begin
                        cfg_sr_d   = {cfg_sr_q[4:0], sdi_sync};
                        cfg_cnt_d  = cfg_cnt_q + 3'd1;
                        cfg_pend_d = (cfg_cnt_q == 3'd5);
                    end
                end else if (clk_fall) begin
                    if (idx_q != 4'd0) begin
                        idx_d = idx_q - 4'd1;
                        sdo_d = conv_q[idx_q - 4'd1];
                    end else begin
                        state_d = IDLE;
                        sdo_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sdo_d   = 1'b0;
            end
        endcase
    end

    // FSM state and datapath registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            conv_q      <= '0;
            idx_q       <= '0;
            cfg_cnt_q   <= '0;
            cfg_sr_q    <= '0;
            cfg_pend_q  <= 1'b0;
            cfg_word_q  <= '0;
            cfg_valid_q <= 1'b0;
            strobe_q    <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            conv_q      <= conv_d;
            idx_q       <= idx_d;
            cfg_cnt_q   <= cfg_cnt_d;
            cfg_sr_q    <= cfg_sr_d;
            cfg_pend_q  <= cfg_pend_d;
            cfg_word_q  <= cfg_word_d;
            cfg_valid_q <= cfg_valid_d;
            strobe_q    <= strobe_d;
            sdo_q       <= sdo_d;
        end
    end

    assign adc_sdo     = sdo_q;
    assign busy        = (state_q == CONVERT);
    assign cfg_word    = cfg_word_q;
    assign ch_sel      = cfg_word_q[4:2];
    assign cfg_valid   = cfg_valid_q;
    assign conv_strobe = strobe_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: a transaction-level model predicts every output
// each cycle, and directed scenarios add literal expectations.
module tb_adc_responder;

    localparam int SYNC_STAGES = 2;
    localparam int CONV_CYCLES = 80;
    localparam int LAT = SYNC_STAGES;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        adc_clk;
    logic        adc_convst;
    logic        adc_sdi;
    logic        adc_sdo;
    logic [11:0] sample_data;
    logic [2:0]  ch_sel;
    logic [5:0]  cfg_word;
    logic        cfg_valid;
    logic        conv_strobe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    adc_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .CONV_CYCLES(CONV_CYCLES)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .adc_clk      (adc_clk),
        .adc_convst   (adc_convst),
        .adc_sdi      (adc_sdi),
        .adc_sdo      (adc_sdo),
        .sample_data  (sample_data),
        .ch_sel       (ch_sel),
        .cfg_word     (cfg_word),
        .cfg_valid    (cfg_valid),
        .conv_strobe  (conv_strobe),
        .busy         (busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Synchronization is a pure delay of LAT cycles on the pin samples;
    // behaviour is then described as "conversion cycles left", "bits sent
    // in the frame" and "config bits collected".
    logic        h_clk [0:LAT+1];
    logic        h_cs  [0:LAT+1];
    logic        h_sdi [0:LAT+1];
    int          n_edges     = 0;
    int          m_busy_left = 0;
    bit          m_in_frame  = 0;
    int          m_bits_sent = 0;
    logic [11:0] m_sample    = '0;
    logic [5:0]  m_cfg       = '0;
    logic [5:0]  m_cfg_next  = '0;
    bit          m_commit    = 0;
    bit          m_cfg_valid = 0;
    bit          m_strobe    = 0;
    bit          cfg_q[$];
    bit          e_cs_rise, e_ck_rise, e_ck_fall, e_sdi;

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i <= LAT + 1; i++) begin
                h_clk[i] = 1'b0;
                h_cs[i]  = 1'b0;
                h_sdi[i] = 1'b0;
            end
            n_edges     = 0;
            m_busy_left = 0;
            m_in_frame  = 0;
            m_bits_sent = 0;
            m_sample    = '0;
            m_cfg       = '0;
            m_commit    = 0;
            m_cfg_valid = 0;
            m_strobe    = 0;
            cfg_q.delete();
        end else begin
            for (int i = LAT + 1; i > 0; i--) begin
                h_clk[i] = h_clk[i-1];
                h_cs[i]  = h_cs[i-1];
                h_sdi[i] = h_sdi[i-1];
            end
            h_clk[0] = adc_clk;
            h_cs[0]  = adc_convst;
            h_sdi[0] = adc_sdi;
            n_edges++;
            e_cs_rise = (n_edges >= LAT + 2) && h_cs[LAT] && !h_cs[LAT+1];
            e_ck_rise = h_clk[LAT] && !h_clk[LAT+1];
            e_ck_fall = !h_clk[LAT] && h_clk[LAT+1];
            e_sdi     = h_sdi[LAT];

            m_strobe    = 0;
            m_cfg_valid = 0;
            if (m_commit) begin
                m_cfg       = m_cfg_next;
                m_cfg_valid = 1;
                m_commit    = 0;
            end

            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_in_frame  = 1;
                    m_bits_sent = 0;
                    cfg_q.delete();
                end
            end else if (e_cs_rise) begin
                m_sample    = sample_data;
                m_busy_left = CONV_CYCLES;
                m_in_frame  = 0;
                m_strobe    = 1;
            end else if (m_in_frame) begin
                if (e_ck_rise) begin
                    if (cfg_q.size() < 6) begin
                        cfg_q.push_back(e_sdi);
                        if (cfg_q.size() == 6) begin
                            for (int i = 0; i < 6; i++) m_cfg_next[5-i] = cfg_q[i];
                            m_commit = 1;
                        end
                    end
                end else if (e_ck_fall) begin
                    if (m_bits_sent == 11) m_in_frame = 0;
                    else m_bits_sent++;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit cmp_en = 0;
    logic exp_sdo;

    always @(negedge clk_clk) begin
        if (cmp_en) begin
            exp_sdo = m_in_frame ? m_sample[11 - m_bits_sent] : 1'b0;
            chk("model adc_sdo", 32'(adc_sdo), 32'(exp_sdo));
            chk("model busy", 32'(busy), 32'(m_busy_left > 0));
            chk("model cfg_word", 32'(cfg_word), 32'(m_cfg));
            chk("model ch_sel", 32'(ch_sel), 32'(m_cfg[4:2]));
            chk("model cfg_valid", 32'(cfg_valid), 32'(m_cfg_valid));
            chk("model conv_strobe", 32'(conv_strobe), 32'(m_strobe));
        end
    end

    // ---------------- event counters ----------------
    int strobe_cnt = 0;
    int busy_cnt   = 0;
    int valid_cnt  = 0;

    always @(negedge clk_clk) begin
        if (conv_strobe) strobe_cnt++;
        if (busy) busy_cnt++;
        if (cfg_valid) valid_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int k);
        repeat (k) @(negedge clk_clk);
    endtask

    task automatic pulse_convst();
        adc_convst = 1'b1;
        cyc(4);
        adc_convst = 1'b0;
    endtask

    // nbits adc_clk periods of 10 system clocks; sdi set before each rise,
    // sdo sampled late in the high phase as the controller would
    task automatic run_clocks(input int nbits, input logic [11:0] sdi_bits, output logic [11:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            adc_sdi = sdi_bits[11-i];
            cyc(1);
            adc_clk = 1'b1;
            cyc(5);
            got[11-i] = adc_sdo;
            adc_clk = 1'b0;
            cyc(4);
        end
    endtask

    task automatic toggle_clk(input int n);
        for (int i = 0; i < n; i++) begin
            adc_clk = 1'b1;
            cyc(3);
            adc_clk = 1'b0;
            cyc(3);
        end
    endtask

    logic [11:0] got;
    int s_strobe, s_busy, s_valid;

    initial begin
        reset_reset_n = 1'b0;
        adc_clk       = 1'b0;
        adc_convst    = 1'b0;
        adc_sdi       = 1'b0;
        sample_data   = '0;
        cyc(2);
        cmp_en = 1;
        cyc(3);
        chk("reset adc_sdo", 32'(adc_sdo), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset cfg_word", 32'(cfg_word), 32'd0);
        chk("reset ch_sel", 32'(ch_sel), 32'd0);
        reset_reset_n = 1'b1;
        cyc(5);

        // basic frame with config capture
        sample_data = 12'hA5C;
        s_strobe = strobe_cnt; s_busy = busy_cnt; s_valid = valid_cnt;
        pulse_convst();
        cyc(CONV_CYCLES + 10);
        chk("basic strobe count", 32'(strobe_cnt - s_strobe), 32'd1);
        chk("basic busy cycles", 32'(busy_cnt - s_busy), 32'd80);
        run_clocks(12, 12'b101110_010101, got);
        chk("basic serial data", 32'(got), 32'hA5C);
        chk("cfg word", 32'(cfg_word), 32'b101110);
        chk("cfg ch_sel", 32'(ch_sel), 32'b011);
        chk("cfg valid count", 32'(valid_cnt - s_valid), 32'd1);
        cyc(6);
        chk("basic sdo after frame", 32'(adc_sdo), 32'd0);

        // abort after five falls
        sample_data = 12'h9E7;
        pulse_convst();
        cyc(CONV_CYCLES + 10);
        run_clocks(5, 12'b010100_000000, got);
        chk("abort partial bits", 32'(got[11:7]), 32'b10011);
        sample_data = 12'h123;
        s_strobe = strobe_cnt;
        pulse_convst();
        chk("abort busy", 32'(busy), 32'd1);
        chk("abort strobe count", 32'(strobe_cnt - s_strobe), 32'd1);
        chk("abort cfg unchanged", 32'(cfg_word), 32'b101110);
        cyc(CONV_CYCLES + 10);
        run_clocks(12, 12'b010011_111111, got);
        chk("abort next frame data", 32'(got), 32'h123);
        chk("second cfg word", 32'(cfg_word), 32'b010011);
        chk("second ch_sel", 32'(ch_sel), 32'b100);
        cyc(6);

        // ignored events in IDLE and CONVERT
        toggle_clk(4);
        chk("idle toggles sdo", 32'(adc_sdo), 32'd0);
        chk("idle toggles busy", 32'(busy), 32'd0);
        sample_data = 12'h5A3;
        s_strobe = strobe_cnt; s_busy = busy_cnt;
        pulse_convst();
        toggle_clk(5);
        sample_data = 12'hFFF;
        pulse_convst();
        cyc(2);
        chk("convert ignores busy", 32'(busy), 32'd1);
        chk("convert ignores sdo", 32'(adc_sdo), 32'd0);
        cyc(70);
        chk("ignored busy cycles", 32'(busy_cnt - s_busy), 32'd80);
        chk("ignored strobe count", 32'(strobe_cnt - s_strobe), 32'd1);
        run_clocks(12, 12'b010011_000000, got);
        chk("ignored frame data", 32'(got), 32'h5A3);
        cyc(6);

        // boundary values back to back
        sample_data = 12'hFFF;
        pulse_convst();
        cyc(CONV_CYCLES + 10);
        run_clocks(12, 12'b010011_000000, got);
        chk("all ones frame", 32'(got), 32'hFFF);
        cyc(6);
        chk("sdo between frames", 32'(adc_sdo), 32'd0);
        sample_data = 12'h000;
        pulse_convst();
        cyc(CONV_CYCLES + 10);
        chk("sdo zero frame start", 32'(adc_sdo), 32'd0);
        run_clocks(12, 12'b010011_000000, got);
        chk("all zeros frame", 32'(got), 32'h000);
        cyc(6);

        // reset mid-shift with convst held high
        sample_data = 12'h6B1;
        adc_convst = 1'b1;
        cyc(CONV_CYCLES + 10);
        run_clocks(3, 12'b111000_000000, got);
        chk("pre-reset bits", 32'(got[11:9]), 32'b011);
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("mid reset adc_sdo", 32'(adc_sdo), 32'd0);
        chk("mid reset busy", 32'(busy), 32'd0);
        chk("mid reset cfg_word", 32'(cfg_word), 32'd0);
        chk("mid reset ch_sel", 32'(ch_sel), 32'd0);
        chk("mid reset cfg_valid", 32'(cfg_valid), 32'd0);
        chk("mid reset conv_strobe", 32'(conv_strobe), 32'd0);
        cyc(3);
        reset_reset_n = 1'b1;
        s_strobe = strobe_cnt; s_busy = busy_cnt;
        cyc(60);
        chk("held convst no strobe", 32'(strobe_cnt - s_strobe), 32'd0);
        chk("held convst no busy", 32'(busy_cnt - s_busy), 32'd0);
        adc_convst = 1'b0;
        cyc(5);
        sample_data = 12'h0F0;
        adc_convst = 1'b1;
        cyc(10);
        chk("re-armed strobe", 32'(strobe_cnt - s_strobe), 32'd1);
        chk("re-armed busy", 32'(busy), 32'd1);
        adc_convst = 1'b0;
        cyc(CONV_CYCLES + 5);
        run_clocks(12, 12'b000000_000000, got);
        chk("post-reset frame data", 32'(got), 32'h0F0);
        cyc(6);

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_responder.md
ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth (at least 2) applied to adc_clk, adc_convst and adc_sdi.
REQ-002 Parameter CONV_CYCLES, default 80, SHALL set the conversion time in clk_clk cycles (at least 1).
REQ-003 clk_clk  in  1  system clock; the only clock in the block.
REQ-004 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-005 adc_clk  in  1  serial clock from the ADC controller; asynchronous to clk_clk.
REQ-006 adc_convst  in  1  conversion start from the controller; asynchronous.
REQ-007 adc_sdi  in  1  serial configuration bits from the controller; asynchronous.
REQ-008 adc_sdo  out  1  serial conversion result to the controller, MSB first.
REQ-009 sample_data  in  12  analog sample value presented by the local sample source.
REQ-010 ch_sel  out  3  channel currently selected; equals cfg_word[4:2].
REQ-011 cfg_word  out  6  last complete config word: {S/D, O/S, S1, S0, UNI, SLP}.
REQ-012 cfg_valid  out  1  one-cycle pulse when cfg_word updates.
REQ-013 conv_strobe  out  1  one-cycle pulse when sample_data is captured.
REQ-014 busy  out  1  high while in CONVERT.

Function
REQ-015 Synchronizing and edge detection: each async input SHALL pass through SYNC_STAGES flops plus one edge-detect register, giving a detected rise or fall SYNC_STAGES+1 cycles after the pin transition (±1 cycle of sampling uncertainty).
REQ-016 The block SHALL implement states IDLE, CONVERT and SHIFT.
REQ-017 IDLE: adc_sdo=0; adc_clk edges are ignored.
REQ-018 IDLE to CONVERT on a detected adc_convst rise.
  - In that cycle: latch sample_data into conv_reg, pulse conv_strobe, load the conversion counter with CONV_CYCLES-1.
REQ-019 CONVERT: busy=1, adc_sdo=0.
  - adc_clk edges and further adc_convst rises are ignored.
  - The counter decrements each cycle.
  - Leaving CONVERT: at count 0, go to SHIFT with adc_sdo=conv_reg[11], bit index=11, cfg bit count=0.
REQ-020 SHIFT, on each detected adc_clk rise while cfg bit count<6: shift the synchronized adc_sdi into the cfg shift register LSB, shifting left, and increment the count.
REQ-021 SHIFT, cfg word completion: when the count reaches 6, cfg_word SHALL load the shift register on the following cycle, with a one-cycle cfg_valid pulse in that same cycle.
  - Rises after the sixth are ignored.
REQ-022 SHIFT, on each detected adc_clk fall: if the index is greater than 0, decrement it and drive adc_sdo=conv_reg[new index].
  - If the index is 0, go to IDLE with adc_sdo=0; a frame is 12 bits.
REQ-023 A simultaneous rise and fall in one cycle is impossible after synchronization. A rise and a fall SHALL never be processed in the same cycle.
REQ-024 An adc_convst rise during SHIFT SHALL abort the frame and enter CONVERT per REQ-018.
  - The partial cfg bits are discarded and cfg_word is unchanged.
REQ-025 conv_reg SHALL change only on a conversion start. adc_sdo SHALL change only on a state entry or a detected adc_clk fall.
REQ-026 ch_sel SHALL be combinational from cfg_word; the new channel applies to the next conversion.

Reset
REQ-027 Asserting reset_reset_n low SHALL immediately force the following, aborting any conversion or frame:
  - state IDLE; adc_sdo=0; busy=0; cfg_valid=0; conv_strobe=0;
  - cfg_word=6'b000000, ch_sel=0; conv_reg=0;
  - all counters and synchronizer flops = 0.
REQ-028 After deassertion, a high adc_convst level SHALL NOT count as a rise. Only a 0-to-1 transition after reset starts a conversion.

Verification
REQ-029 Basic frame: sample_data=12'hA5C, convst pulse, wait CONV_CYCLES, 12 adc_clk periods (10 clk_clk each) -> conv_strobe once; busy high 80 cycles; serial bits 1010_0101_1100; adc_sdo=0 after the 12th fall.
REQ-030 Config capture: adc_sdi bits 1,0,1,1,1,0 on the first six rises -> cfg_word=6'b101110, cfg_valid one cycle, ch_sel=3'b011; bits 7-12 of adc_sdi have no effect.
REQ-031 Abort: convst rise after 5 falls with sample_data=12'h123 -> conv_strobe; busy high; cfg_word unchanged; the next frame shifts 12'h123.
REQ-032 Ignored events: adc_clk toggling during IDLE and CONVERT, and a second convst rise in CONVERT -> no state change, adc_sdo=0, busy duration still 80 cycles.
REQ-033 Reset mid-SHIFT after 3 cfg bits and while adc_convst is held high -> all outputs at reset values; no conversion until adc_convst falls and rises again.
REQ-034 Boundary values: sample_data=12'hFFF then 12'h000 in back-to-back frames -> twelve 1s then twelve 0s; adc_sdo returns to 0 between frames.
